// File: rtl/mem_rd_arbiter_pkg.sv
// Shared types and sizing for the two-master memory read arbiter.
package mem_rd_arbiter_pkg;

    localparam int unsigned BEATS  = 8;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(BEATS);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_REQ  = 3'b010,
        ST_RSP  = 3'b100
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_rd_arbiter_rr2.sv
// Two-way round-robin pick; the priority bit moves to the loser only on a grant.
module mem_rd_arbiter_rr2
    import mem_rd_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic       win_o
);

    owner_e prio_q, prio_d;

    always_comb begin
        win_o  = prio_q;
        prio_d = prio_q;
        if (req_i == 2'b01) begin
            win_o = OWN_I;
        end else if (req_i == 2'b10) begin
            win_o = OWN_D;
        end
        if (advance_i) begin
            prio_d = owner_e'(~win_o);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= OWN_D;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Grants one burst read at a time to the I- or D-cache and steers the beats back to the owner.
module mem_rd_arbiter
    import mem_rd_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              from_icache_rd_req_valid,
    input  logic [ADDR_W-1:0] from_icache_rd_req_addr,
    input  logic              from_dcache_rd_req_valid,
    input  logic [ADDR_W-1:0] from_dcache_rd_req_addr,
    output logic              to_icache_rd_req_ready,
    output logic              to_dcache_rd_req_ready,
    output logic              to_icache_rd_rsp_valid,
    output logic              to_dcache_rd_rsp_valid,
    output logic [DATA_W-1:0] to_icache_rd_rsp_data,
    output logic [DATA_W-1:0] to_dcache_rd_rsp_data,
    output logic              to_icache_rd_rsp_last,
    output logic              to_dcache_rd_rsp_last,
    input  logic              from_icache_rd_rsp_ready,
    input  logic              from_dcache_rd_rsp_ready,
    output logic              to_mem_rd_req_valid,
    output logic [ADDR_W-1:0] to_mem_rd_req_addr,
    input  logic              from_mem_rd_req_ready,
    input  logic              from_mem_rd_rsp_valid,
    input  logic [DATA_W-1:0] from_mem_rd_rsp_data,
    input  logic              from_mem_rd_rsp_last,
    output logic              to_mem_rd_rsp_ready,
    output logic              rd_proto_err
);

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic [CNT_W-1:0]   beat_q,  beat_d;
    logic               err_q,   err_d;
    logic               win_c;
    logic               grant_c;
    logic               hs_c;

    mem_rd_arbiter_rr2 u_rr2 (
        .clk       (clk),
        .rst       (rst),
        .req_i     ({from_dcache_rd_req_valid, from_icache_rd_req_valid}),
        .advance_i (grant_c),
        .win_o     (win_c)
    );

    assign to_icache_rd_rsp_data = from_mem_rd_rsp_data;
    assign to_dcache_rd_rsp_data = from_mem_rd_rsp_data;
    assign rd_proto_err          = err_q;

    always_comb begin
        state_d                = state_q;
        owner_d                = owner_q;
        addr_d                 = addr_q;
        beat_d                 = beat_q;
        err_d                  = err_q;
        grant_c                = 1'b0;
        hs_c                   = 1'b0;
        to_icache_rd_req_ready = 1'b0;
        to_dcache_rd_req_ready = 1'b0;
        to_icache_rd_rsp_valid = 1'b0;
        to_dcache_rd_rsp_valid = 1'b0;
        to_icache_rd_rsp_last  = 1'b0;
        to_dcache_rd_rsp_last  = 1'b0;
        to_mem_rd_req_valid    = 1'b0;
        to_mem_rd_req_addr     = '0;
        to_mem_rd_rsp_ready    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (from_icache_rd_req_valid || from_dcache_rd_req_valid) begin
                    grant_c = 1'b1;
                    owner_d = owner_e'(win_c);
                    addr_d  = win_c ? from_dcache_rd_req_addr : from_icache_rd_req_addr;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                to_mem_rd_req_valid = 1'b1;
                to_mem_rd_req_addr  = addr_q;
                if (owner_q == OWN_D) begin
                    to_dcache_rd_req_ready = from_mem_rd_req_ready;
                end else begin
                    to_icache_rd_req_ready = from_mem_rd_req_ready;
                end
                if (from_mem_rd_req_ready) begin
                    beat_d  = '0;
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (owner_q == OWN_D) begin
                    to_dcache_rd_rsp_valid = from_mem_rd_rsp_valid;
                    to_dcache_rd_rsp_last  = from_mem_rd_rsp_last;
                    to_mem_rd_rsp_ready    = from_dcache_rd_rsp_ready;
                end else begin
                    to_icache_rd_rsp_valid = from_mem_rd_rsp_valid;
                    to_icache_rd_rsp_last  = from_mem_rd_rsp_last;
                    to_mem_rd_rsp_ready    = from_icache_rd_rsp_ready;
                end
                hs_c = from_mem_rd_rsp_valid && to_mem_rd_rsp_ready;
                if (hs_c) begin
                    beat_d = beat_q + CNT_W'(1);
                    // Length check: last must land on the final beat and nowhere else.
                    if (from_mem_rd_rsp_last != (beat_q == CNT_W'(BEATS - 1))) begin
                        err_d = 1'b1;
                    end
                    if (from_mem_rd_rsp_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_D;
            addr_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/mem_rd_arbiter.md
# mem_rd_arbiter

Two-master read-channel arbiter between the I-cache and D-cache refill ports and the single memory read port of the custom CPU. It grants one 32-byte burst read at a time with round-robin priority, forwards the granted cache's request address, and steers the returning data beats back to that cache only. It also checks the burst length and reports violations through a sticky error flag.

## Interface
- BEATS, 8: data beats per burst (32-bit beats, 32-byte line).
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- from_icache_rd_req_valid / from_dcache_rd_req_valid  in  1  cache read request valid.
- from_icache_rd_req_addr / from_dcache_rd_req_addr  in  32  32-byte-aligned line address.
- to_icache_rd_req_ready / to_dcache_rd_req_ready  out  1  request accepted by memory.
- to_icache_rd_rsp_valid / to_dcache_rd_rsp_valid  out  1  data beat valid for that cache.
- to_icache_rd_rsp_data / to_dcache_rd_rsp_data  out  32  beat data; both carry from_mem_rd_rsp_data.
- to_icache_rd_rsp_last / to_dcache_rd_rsp_last  out  1  final beat; gated like valid.
- from_icache_rd_rsp_ready / from_dcache_rd_rsp_ready  in  1  cache accepts beat.
- to_mem_rd_req_valid  out  1;  to_mem_rd_req_addr  out  32;  from_mem_rd_req_ready  in  1.
- from_mem_rd_rsp_valid  in  1;  from_mem_rd_rsp_data  in  32;  from_mem_rd_rsp_last  in  1;  to_mem_rd_rsp_ready  out  1.
- rd_proto_err  out  1  sticky burst-length violation flag.

## Operation
- FSM, one-hot: IDLE, REQ, RSP.
- IDLE: if any request valid, pick winner, latch owner and its addr, go to REQ. Both valid: winner is prio; prio then points to the loser. One valid: grant it; prio points to the other.
- REQ: to_mem_rd_req_valid=1, to_mem_rd_req_addr=latched addr. Owner's req_ready = from_mem_rd_req_ready; other's req_ready=0. On from_mem_rd_req_ready: clear beat counter, go to RSP.
- RSP: owner's rsp_valid/rsp_last = from_mem_rd_rsp_valid/last; to_mem_rd_rsp_ready = owner's rsp_ready; non-owner valid/last = 0. Each handshake (valid & ready) increments 3-bit beat counter (wraps modulo 8). Handshake with last: go to IDLE.
- Error: set rd_proto_err when last handshakes with counter != BEATS-1, or a non-last beat handshakes with counter == BEATS-1. Clears only on rst. Burst completion still follows last.
- Requesters hold valid and addr stable until req_ready; arbiter does not re-sample addr after the grant.
- Outside REQ/RSP all handshake outputs are 0; to_mem_rd_req_addr is 0 in IDLE.

## Timing
- Reset: state IDLE; prio = D-cache; owner = D-cache; addr, beat counter = 0; rd_proto_err = 0; all valid/ready/last outputs 0.
- Request valid in IDLE at cycle t -> to_mem_rd_req_valid at t+1.
- Memory accepts at cycle t -> owner req_ready high in that same cycle; RSP from t+1.
- Response path is combinational pass-through; zero added latency per beat; backpressure passes through unchanged.
- Last handshake at t -> IDLE at t+1 -> next grant in REQ at t+2. Minimum gap between bursts: 1 idle cycle.
- Request arriving during REQ/RSP waits, with no ready, until the next IDLE.
- rst mid-burst: FSM returns to IDLE next cycle, no beat is forwarded, and the memory side must be reset alongside.

## Structure
- Shared header `mem_arb_defs.vh`: state localparams (one-hot codes and bit indices), BEATS default, owner encoding (0 = I-cache, 1 = D-cache).
- Optional sub-module `rd_arb_rr2`: 2-way round-robin grant with registered prio bit, advanced only on IDLE->REQ. Everything else stays in the top module.

## Test plan
- Single I-cache request addr 0x0000_1020, memory ready immediately, 8 beats 0xA0..0xA7 -> to_mem_rd_req_addr=0x0000_1020 at t+1; I-cache receives 8 beats in order with last on 0xA7; D-cache rsp_valid stays 0; IDLE after last.
- Both valid simultaneously after reset -> D-cache granted first; I-cache granted at its next IDLE; a third simultaneous pair goes to D-cache (alternation).
- from_mem_rd_req_ready held low 5 cycles -> owner req_ready low for those cycles and high exactly in the accept cycle; addr stable throughout.
- Owner rsp_ready toggled 1,0,1,0 during burst -> to_mem_rd_rsp_ready mirrors it; beat counter advances only on handshakes; all 8 beats delivered.
- Memory asserts last on beat 6 -> rd_proto_err=1 next cycle and stays 1 across later good bursts until rst.
- rst asserted on beat 3 of a burst -> next cycle state IDLE, all outputs 0, rd_proto_err=0, prio = D-cache.
